// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared types and defaults for the branch resolver
package branch_resolver_pkg;
  localparam int XLEN      = 32;
  localparam int BRQ_DEPTH = 8;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } pred_entry_t;
endpackage

// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - fetch/execute/BTB signal bundle seen by the branch resolver
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic            pred_valid_i;
  logic            pred_ready_o;
  logic [XLEN-1:0] pred_pc_i;
  logic            pred_hit_i;
  logic [XLEN-1:0] pred_target_i;
  logic            res_valid_i;
  logic            res_ready_o;
  logic            res_taken_i;
  logic [XLEN-1:0] res_target_i;
  logic            btb_valid_o;
  logic            btb_del_entry_o;
  logic [XLEN-1:0] btb_update_pc_o;
  logic [XLEN-1:0] btb_target_o;
  logic            mispred_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    input  pred_valid_i, pred_pc_i, pred_hit_i, pred_target_i,
    input  res_valid_i, res_taken_i, res_target_i,
    output pred_ready_o, res_ready_o,
    output btb_valid_o, btb_del_entry_o, btb_update_pc_o, btb_target_o,
    output mispred_o, redirect_pc_o
  );

  modport slave (
    output pred_valid_i, pred_pc_i, pred_hit_i, pred_target_i,
    output res_valid_i, res_taken_i, res_target_i,
    input  pred_ready_o, res_ready_o,
    input  btb_valid_o, btb_del_entry_o, btb_update_pc_o, btb_target_o,
    input  mispred_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// rtl/branch_resolver_pred_fifo.sv - in-order queue of fetch-time predictions with synchronous clear
module pred_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  pred_entry_t push_data_i,
  input  logic        pop_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy guards every read that matters.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - matches queued predictions against resolutions, drives BTB update and redirect
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  branch_resolver_if.master bus,
  output logic [CNT_W-1:0]  res_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);
  pred_entry_t push_entry, head;
  logic        full, empty, fifo_clear;
  logic        pop_fire, mispredict, take_upd, del_upd;

  logic             btb_valid_q, btb_valid_d;
  logic             btb_del_q, btb_del_d;
  logic [XLEN-1:0]  btb_pc_q, btb_pc_d;
  logic [XLEN-1:0]  btb_target_q, btb_target_d;
  logic             mispred_q, mispred_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign push_entry = '{hit: bus.pred_hit_i, pc: bus.pred_pc_i, target: bus.pred_target_i};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (fifo_clear),
    .push_i     (bus.pred_valid_i),
    .push_data_i(push_entry),
    .pop_i      (pop_fire),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign pop_fire = bus.res_valid_i && !empty && !flush_i;

  // A taken branch needs a (re)write unless the BTB already holds the right target;
  // a predicted-taken branch that fell through must be evicted.
  assign take_upd   = bus.res_taken_i && (!head.hit || (head.target != bus.res_target_i));
  assign del_upd    = !bus.res_taken_i && head.hit;
  assign mispredict = (head.hit != bus.res_taken_i) ||
                      (head.hit && bus.res_taken_i && (head.target != bus.res_target_i));

  // Younger entries were fetched down the wrong path once the oldest mispredicts.
  assign fifo_clear = flush_i || (pop_fire && mispredict);

  always_comb begin
    btb_valid_d   = pop_fire && (take_upd || del_upd);
    btb_del_d     = pop_fire && del_upd;
    btb_pc_d      = btb_valid_d ? head.pc : '0;
    btb_target_d  = (pop_fire && take_upd) ? bus.res_target_i : '0;
    mispred_d     = pop_fire && mispredict;
    redirect_d    = '0;
    if (mispred_d) redirect_d = bus.res_taken_i ? bus.res_target_i : head.pc + XLEN'(4);
    res_cnt_d     = res_cnt_q + (pop_fire ? CNT_W'(1) : '0);
    mispred_cnt_d = mispred_cnt_q + (mispred_d ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btb_valid_q   <= 1'b0;
      btb_del_q     <= 1'b0;
      btb_pc_q      <= '0;
      btb_target_q  <= '0;
      mispred_q     <= 1'b0;
      redirect_q    <= '0;
      res_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      btb_valid_q   <= btb_valid_d;
      btb_del_q     <= btb_del_d;
      btb_pc_q      <= btb_pc_d;
      btb_target_q  <= btb_target_d;
      mispred_q     <= mispred_d;
      redirect_q    <= redirect_d;
      res_cnt_q     <= res_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.pred_ready_o    = !full;
  assign bus.res_ready_o     = !empty;
  assign bus.btb_valid_o     = btb_valid_q;
  assign bus.btb_del_entry_o = btb_del_q;
  assign bus.btb_update_pc_o = btb_pc_q;
  assign bus.btb_target_o    = btb_target_q;
  assign bus.mispred_o       = mispred_q;
  assign bus.redirect_pc_o   = redirect_q;
  assign res_cnt_o           = res_cnt_q;
  assign mispred_cnt_o       = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] res_cnt, mispred_cnt;
  int          checks = 0;
  int          errors = 0;

  branch_resolver_if bif();

  branch_resolver #(.DEPTH(8), .CNT_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .bus          (bif.master),
    .res_cnt_o    (res_cnt),
    .mispred_cnt_o(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    bif.pred_valid_i  = 1'b1;
    bif.pred_pc_i     = pc;
    bif.pred_hit_i    = hit;
    bif.pred_target_i = tgt;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    bif.res_valid_i  = 1'b1;
    bif.res_taken_i  = taken;
    bif.res_target_i = tgt;
  endtask

  task automatic idle();
    bif.pred_valid_i = 1'b0;
    bif.res_valid_i  = 1'b0;
  endtask

  initial begin
    bif.pred_valid_i  = 1'b0;
    bif.pred_pc_i     = '0;
    bif.pred_hit_i    = 1'b0;
    bif.pred_target_i = '0;
    bif.res_valid_i   = 1'b0;
    bif.res_taken_i   = 1'b0;
    bif.res_target_i  = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_pred_ready", bif.pred_ready_o, 1);
    chk("rst_res_ready", bif.res_ready_o, 0);
    chk("rst_btb_valid", bif.btb_valid_o, 0);
    chk("rst_mispred", bif.mispred_o, 0);
    chk("rst_res_cnt", res_cnt, 0);

    // Not-hit branch resolves taken: install and redirect
    push(32'h100, 1'b0, 32'h0); step(); idle();
    chk("t2_res_ready", bif.res_ready_o, 1);
    resolve(1'b1, 32'h200); step(); idle();
    chk("t2_btb_valid", bif.btb_valid_o, 1);
    chk("t2_btb_del", bif.btb_del_entry_o, 0);
    chk("t2_btb_pc", bif.btb_update_pc_o, 32'h100);
    chk("t2_btb_target", bif.btb_target_o, 32'h200);
    chk("t2_mispred", bif.mispred_o, 1);
    chk("t2_redirect", bif.redirect_pc_o, 32'h200);
    chk("t2_mispred_cnt", mispred_cnt, 1);
    chk("t2_res_cnt", res_cnt, 1);
    step();
    chk("t2_mispred_pulse", bif.mispred_o, 0);
    chk("t2_btb_valid_pulse", bif.btb_valid_o, 0);

    // Hit branch resolves not-taken: delete and fall through
    push(32'h104, 1'b1, 32'h300); step(); idle();
    resolve(1'b0, 32'h0); step(); idle();
    chk("t3_btb_valid", bif.btb_valid_o, 1);
    chk("t3_btb_del", bif.btb_del_entry_o, 1);
    chk("t3_btb_pc", bif.btb_update_pc_o, 32'h104);
    chk("t3_btb_target", bif.btb_target_o, 0);
    chk("t3_mispred", bif.mispred_o, 1);
    chk("t3_redirect", bif.redirect_pc_o, 32'h108);
    chk("t3_mispred_cnt", mispred_cnt, 2);

    // Correct prediction: no action
    push(32'h110, 1'b1, 32'h400); step(); idle();
    resolve(1'b1, 32'h400); step(); idle();
    chk("t4_btb_valid", bif.btb_valid_o, 0);
    chk("t4_mispred", bif.mispred_o, 0);
    chk("t4_res_cnt", res_cnt, 3);
    chk("t4_mispred_cnt", mispred_cnt, 2);

    // Pop while empty is ignored
    resolve(1'b1, 32'h123); step(); idle();
    chk("empty_pop_res_cnt", res_cnt, 3);
    chk("empty_pop_btb_valid", bif.btb_valid_o, 0);

    // Fill, overflow push, push+pop when full
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
      step();
    end
    chk("t5_full_ready", bif.pred_ready_o, 0);
    chk("t5_full_res_ready", bif.res_ready_o, 1);
    push(32'h2000, 1'b0, 32'h0); step();
    push(32'h3000, 1'b0, 32'h0); resolve(1'b0, 32'h0); step();
    bif.res_valid_i = 1'b0;
    chk("t5_pp_btb_valid", bif.btb_valid_o, 0);
    chk("t5_pp_res_cnt", res_cnt, 4);
    chk("t5_pp_ready", bif.pred_ready_o, 1);
    push(32'h1020, 1'b0, 32'h0); step(); idle();
    chk("t5_refull_ready", bif.pred_ready_o, 0);
    resolve(1'b1, 32'h500); step(); idle();
    chk("t5_mp_mispred", bif.mispred_o, 1);
    chk("t5_mp_btb_pc", bif.btb_update_pc_o, 32'h1004);
    chk("t5_mp_redirect", bif.redirect_pc_o, 32'h500);
    chk("t5_mp_res_ready", bif.res_ready_o, 0);
    chk("t5_mp_pred_ready", bif.pred_ready_o, 1);
    chk("t5_mp_res_cnt", res_cnt, 5);
    chk("t5_mp_mispred_cnt", mispred_cnt, 3);

    // Push coinciding with a mispredict pop is dropped
    push(32'h600, 1'b0, 32'h0); step(); idle();
    push(32'h604, 1'b0, 32'h0); resolve(1'b1, 32'h700); step(); idle();
    chk("drop_mispred", bif.mispred_o, 1);
    chk("drop_redirect", bif.redirect_pc_o, 32'h700);
    chk("drop_res_ready", bif.res_ready_o, 0);
    chk("drop_mispred_cnt", mispred_cnt, 4);

    // Flush beats a same-cycle mispredicting pop
    push(32'h800, 1'b1, 32'h900); step(); idle();
    flush = 1'b1; resolve(1'b0, 32'h0); step();
    flush = 1'b0; idle();
    chk("t6_res_ready", bif.res_ready_o, 0);
    chk("t6_btb_valid", bif.btb_valid_o, 0);
    chk("t6_mispred", bif.mispred_o, 0);
    chk("t6_res_cnt", res_cnt, 6);
    chk("t6_mispred_cnt", mispred_cnt, 4);

    // Reset mid-traffic
    push(32'h900, 1'b0, 32'h0); step(); idle();
    push(32'h904, 1'b0, 32'h0); resolve(1'b1, 32'hA00); step(); idle();
    chk("t1_pre_mispred", bif.mispred_o, 1);
    chk("t1_pre_res_cnt", res_cnt, 7);
    rst = 1'b1;
    #1;
    chk("t1_pred_ready", bif.pred_ready_o, 1);
    chk("t1_res_ready", bif.res_ready_o, 0);
    chk("t1_btb_valid", bif.btb_valid_o, 0);
    chk("t1_mispred", bif.mispred_o, 0);
    chk("t1_res_cnt", res_cnt, 0);
    chk("t1_mispred_cnt", mispred_cnt, 0);
    step();
    rst = 1'b0;
    step();
    chk("t1_post_res_ready", bif.res_ready_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
